ddr4_cmd_scheduler: RTL and testbench

- Two-port (read/write) DDR4 command scheduler that drives the DDR4 command bus (CS_n, ACT_n, adr, ba, bg) seen by the command decode monitor.
- Tracks the open row per bank.
- Issues PRE/ACT/RD/WR with tRP/tRCD/tCCD spacing.
- Round-robin arbitrates between requesters and inserts periodic PREA+REF.

---
 rtl/ddr4_cmd_scheduler.sv | 252 +++++++++++++++++++++++++
 tb/tb_ddr4_cmd_scheduler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ddr4_cmd_scheduler.sv
// Two-port DDR4 command scheduler: open-page bank tracking, tRP/tRCD/tCCD spacing,
// round-robin read/write arbitration and periodic PREA+REF. Optional: AUTO_PRECHARGE_EN.
module ddr4_cmd_scheduler #(
  parameter int unsigned T_RCD  = 4,
  parameter int unsigned T_RP   = 4,
  parameter int unsigned T_CCD  = 2,
  parameter int unsigned T_RFC  = 32,
  parameter int unsigned T_REFI = 1000,
  parameter int unsigned CNT_W  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_valid,
  output logic        rd_ready,
  input  logic [1:0]  rd_bg,
  input  logic [1:0]  rd_ba,
  input  logic [16:0] rd_row,
  input  logic [9:0]  rd_col,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [1:0]  wr_bg,
  input  logic [1:0]  wr_ba,
  input  logic [16:0] wr_row,
  input  logic [9:0]  wr_col,
  output logic        CS_n,
  output logic        ACT_n,
  output logic [16:0] adr,
  output logic [1:0]  ba,
  output logic [1:0]  bg,
  output logic        refresh_pending,
  output logic        busy
);

  typedef enum logic [3:0] {
    StIdle, StPre, StWaitRp, StAct, StWaitRcd, StCas,
    StRefPrea, StRefWaitRp, StRef, StRefWaitRfc
  } state_e;

  // Wait states last (load + 1) cycles before the next command state.
  localparam logic [CNT_W-1:0] LP_RP_LD   = CNT_W'(T_RP - 2);
  localparam logic [CNT_W-1:0] LP_RCD_LD  = CNT_W'(T_RCD - 2);
  localparam logic [CNT_W-1:0] LP_RFC_LD  = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W-1:0] LP_CCD_LD  = CNT_W'(T_CCD - 1);
  localparam logic [CNT_W-1:0] LP_REFI_LD = CNT_W'(T_REFI - 1);
`ifdef AUTO_PRECHARGE_EN
  localparam logic             LP_AP      = 1'b1;
  localparam logic [CNT_W-1:0] LP_AP_LD   = CNT_W'(T_RP - 1);
`else
  localparam logic             LP_AP      = 1'b0;
`endif

  state_e            r_state, w_state_nxt;
  logic [15:0]       r_open;
  logic [16:0]       r_open_row [16];
  logic              r_is_wr;
  logic [1:0]        r_ba, r_bg;
  logic [16:0]       r_req_row;
  logic [9:0]        r_req_col;
  logic [CNT_W-1:0]  r_wait, w_wait_nxt;
  logic [CNT_W-1:0]  r_ccd;
  logic [CNT_W-1:0]  r_refi;
  logic              r_pending;
  logic              r_rr_rd;
`ifdef AUTO_PRECHARGE_EN
  logic [CNT_W-1:0]  r_ap_wait;
`endif

  logic              w_grant, w_grant_wr;
  logic [1:0]        w_sel_ba, w_sel_bg;
  logic [16:0]       w_sel_row;
  logic [3:0]        w_sel_bank, w_bank;
  logic              w_do_act, w_do_pre, w_do_cas, w_clr_all, w_ref_issue;
  logic              w_act_ok, w_any_open;

  assign w_grant_wr = wr_valid & (~rd_valid | ~r_rr_rd);
  assign w_sel_ba   = w_grant_wr ? wr_ba  : rd_ba;
  assign w_sel_bg   = w_grant_wr ? wr_bg  : rd_bg;
  assign w_sel_row  = w_grant_wr ? wr_row : rd_row;
  assign w_sel_bank = {w_sel_ba, w_sel_bg};
  assign w_bank     = {r_ba, r_bg};
  assign w_any_open = |r_open;
  assign busy       = (r_state != StIdle);
  assign refresh_pending = r_pending;

`ifdef AUTO_PRECHARGE_EN
  assign w_act_ok = (r_ap_wait == '0);
`else
  assign w_act_ok = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = (r_wait != '0) ? r_wait - 1'b1 : r_wait;
    CS_n        = 1'b1;
    ACT_n       = 1'b1;
    adr         = 17'h1C000;
    ba          = 2'b00;
    bg          = 2'b00;
    rd_ready    = 1'b0;
    wr_ready    = 1'b0;
    w_grant     = 1'b0;
    w_do_act    = 1'b0;
    w_do_pre    = 1'b0;
    w_do_cas    = 1'b0;
    w_clr_all   = 1'b0;
    w_ref_issue = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_pending) begin
          w_state_nxt = w_any_open ? StRefPrea : StRef;
        end else if (rd_valid || wr_valid) begin
          w_grant = 1'b1;
          if (r_open[w_sel_bank] && (r_open_row[w_sel_bank] == w_sel_row)) begin
            w_state_nxt = StCas;
          end else if (r_open[w_sel_bank]) begin
            w_state_nxt = StPre;
          end else begin
            w_state_nxt = StAct;
          end
        end
      end
      StPre: begin
        CS_n        = 1'b0;
        adr         = 17'h08000;
        ba          = r_ba;
        bg          = r_bg;
        w_do_pre    = 1'b1;
        w_wait_nxt  = LP_RP_LD;
        w_state_nxt = StWaitRp;
      end
      StWaitRp: if (r_wait == '0) w_state_nxt = StAct;
      StAct: begin
        if (w_act_ok) begin
          CS_n        = 1'b0;
          ACT_n       = 1'b0;
          adr         = r_req_row;
          ba          = r_ba;
          bg          = r_bg;
          w_do_act    = 1'b1;
          w_wait_nxt  = LP_RCD_LD;
          w_state_nxt = StWaitRcd;
        end
      end
      StWaitRcd: if (r_wait == '0) w_state_nxt = StCas;
      StCas: begin
        if (r_ccd == '0) begin
          CS_n        = 1'b0;
          adr         = {2'b10, ~r_is_wr, 3'b000, LP_AP, r_req_col};
          ba          = r_ba;
          bg          = r_bg;
          rd_ready    = ~r_is_wr;
          wr_ready    = r_is_wr;
          w_do_cas    = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      StRefPrea: begin
        CS_n        = 1'b0;
        adr         = 17'h08400;
        w_clr_all   = 1'b1;
        w_wait_nxt  = LP_RP_LD;
        w_state_nxt = StRefWaitRp;
      end
      StRefWaitRp: if (r_wait == '0) w_state_nxt = StRef;
      StRef: begin
        if (w_act_ok) begin
          CS_n        = 1'b0;
          adr         = 17'h04000;
          w_clr_all   = 1'b1;
          w_ref_issue = 1'b1;
          w_wait_nxt  = LP_RFC_LD;
          w_state_nxt = StRefWaitRfc;
        end
      end
      StRefWaitRfc: if (r_wait == '0) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_wait  <= '0;
      r_ccd   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      if (w_do_cas)          r_ccd <= LP_CCD_LD;
      else if (r_ccd != '0)  r_ccd <= r_ccd - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_wr   <= 1'b0;
      r_ba      <= 2'b00;
      r_bg      <= 2'b00;
      r_req_row <= '0;
      r_req_col <= '0;
      r_rr_rd   <= 1'b1;
    end else if (w_grant) begin
      r_is_wr   <= w_grant_wr;
      r_ba      <= w_sel_ba;
      r_bg      <= w_sel_bg;
      r_req_row <= w_sel_row;
      r_req_col <= w_grant_wr ? wr_col : rd_col;
      // Whoever just won yields priority to the other port.
      r_rr_rd   <= w_grant_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_open <= '0;
      for (int i = 0; i < 16; i++) r_open_row[i] <= '0;
    end else if (w_clr_all) begin
      r_open <= '0;
    end else if (w_do_pre) begin
      r_open[w_bank] <= 1'b0;
    end else if (w_do_act) begin
      r_open[w_bank]     <= 1'b1;
      r_open_row[w_bank] <= r_req_row;
    end else if (w_do_cas && LP_AP) begin
      r_open[w_bank] <= 1'b0;
    end
  end

  // An expiry while a refresh is still owed is deliberately dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refi    <= LP_REFI_LD;
      r_pending <= 1'b0;
    end else begin
      r_refi <= (r_refi == '0) ? LP_REFI_LD : r_refi - 1'b1;
      if (w_ref_issue)        r_pending <= 1'b0;
      else if (r_refi == '0)  r_pending <= 1'b1;
    end
  end

`ifdef AUTO_PRECHARGE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ap_wait <= '0;
    end else if (w_do_cas) begin
      r_ap_wait <= LP_AP_LD;
    end else if (r_ap_wait != '0) begin
      r_ap_wait <= r_ap_wait - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr4_cmd_scheduler.sv
// Directed self-checking bench for ddr4_cmd_scheduler; a second instance with
// T_REFI=50 exercises the refresh sequence.
module tb_ddr4_cmd_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rd_valid, rd_ready, wr_valid, wr_ready;
  logic [1:0]  rd_bg, rd_ba, wr_bg, wr_ba, ba, bg;
  logic [16:0] rd_row, wr_row, adr;
  logic [9:0]  rd_col, wr_col;
  logic        cs_n, act_n, refresh_pending, busy;

  logic        rst2_n, rd2_valid, rd2_ready, wr2_ready;
  logic [1:0]  ba2, bg2;
  logic [16:0] adr2;
  logic        cs2_n, act2_n, pend2, busy2;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [22:0] DESEL = {1'b1, 1'b1, 17'h1C000, 2'b00, 2'b00};

  ddr4_cmd_scheduler u_dut (
    .clk(clk), .rst_n(rst_n),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_bg(rd_bg), .rd_ba(rd_ba),
    .rd_row(rd_row), .rd_col(rd_col),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_bg(wr_bg), .wr_ba(wr_ba),
    .wr_row(wr_row), .wr_col(wr_col),
    .CS_n(cs_n), .ACT_n(act_n), .adr(adr), .ba(ba), .bg(bg),
    .refresh_pending(refresh_pending), .busy(busy)
  );

  ddr4_cmd_scheduler #(.T_REFI(50)) u_dut_ref (
    .clk(clk), .rst_n(rst2_n),
    .rd_valid(rd2_valid), .rd_ready(rd2_ready), .rd_bg(2'd1), .rd_ba(2'd1),
    .rd_row(17'h00123), .rd_col(10'h010),
    .wr_valid(1'b0), .wr_ready(wr2_ready), .wr_bg(2'd0), .wr_ba(2'd0),
    .wr_row(17'h0), .wr_col(10'h0),
    .CS_n(cs2_n), .ACT_n(act2_n), .adr(adr2), .ba(ba2), .bg(bg2),
    .refresh_pending(pend2), .busy(busy2)
  );

  function automatic logic [22:0] bus(input logic c, input logic a, input logic [16:0] ad,
                                      input logic [1:0] b, input logic [1:0] g);
    return {c, a, ad, b, g};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [22:0] bus1();
    return {cs_n, act_n, adr, ba, bg};
  endfunction

  function automatic logic [22:0] bus2();
    return {cs2_n, act2_n, adr2, ba2, bg2};
  endfunction

  initial begin
    logic [1:0] rdy;
    int quiet_bad;
    rst_n = 1'b0; rst2_n = 1'b0;
    rd_valid = 1'b0; wr_valid = 1'b0; rd2_valid = 1'b0;
    rd_bg = '0; rd_ba = '0; rd_row = '0; rd_col = '0;
    wr_bg = '0; wr_ba = '0; wr_row = '0; wr_col = '0;
    tick(); tick();
    check_eq("rst_bus", bus1(), DESEL);
    check_eq("rst_flags", {rd_ready, wr_ready, refresh_pending, busy}, 4'b0000);
    rst_n = 1'b1;
    tick();

    // Closed bank 5: ACT at G+1, RD at G+5.
    rd_ba = 2'd1; rd_bg = 2'd1; rd_row = 17'h00123; rd_col = 10'h010; rd_valid = 1'b1;
    tick();
    check_eq("t1_act", bus1(), bus(1'b0, 1'b0, 17'h00123, 2'd1, 2'd1));
    check_eq("t1_busy", busy, 1'b1);
    tick();
    check_eq("t1_gap", bus1(), DESEL);
    tick(); tick();
    check_eq("t1_noready", rd_ready, 1'b0);
    tick();
    check_eq("t1_rd", bus1(), bus(1'b0, 1'b1, 17'h14010, 2'd1, 2'd1));
    check_eq("t1_ready", rd_ready, 1'b1);
    rd_valid = 1'b0;
    tick();
    check_eq("t1_ready_drop", rd_ready, 1'b0);
    check_eq("t1_idle", bus1(), DESEL);

    // Row hit: RD at G+1, two cycles after the previous RD.
    rd_col = 10'h020; rd_valid = 1'b1;
    tick();
    check_eq("t2_hit", bus1(), bus(1'b0, 1'b1, 17'h14020, 2'd1, 2'd1));
    check_eq("t2_ready", rd_ready, 1'b1);
    rd_valid = 1'b0;
    tick();

    // Row miss on bank 5: PRE, ACT at G+5, WR at G+9.
    wr_ba = 2'd1; wr_bg = 2'd1; wr_row = 17'h00456; wr_col = 10'h033; wr_valid = 1'b1;
    tick();
    check_eq("t3_pre", bus1(), bus(1'b0, 1'b1, 17'h08000, 2'd1, 2'd1));
    tick();
    check_eq("t3_gap", bus1(), DESEL);
    tick(); tick(); tick();
    check_eq("t3_act", bus1(), bus(1'b0, 1'b0, 17'h00456, 2'd1, 2'd1));
    tick(); tick(); tick(); tick();
    check_eq("t3_wr", bus1(), bus(1'b0, 1'b1, 17'h10033, 2'd1, 2'd1));
    check_eq("t3_ready", {rd_ready, wr_ready}, 2'b01);
    wr_valid = 1'b0;
    tick();

    // Both ports held: grants alternate R,W,R,W...
    rd_ba = 2'd0; rd_bg = 2'd0; rd_row = 17'h00010; rd_col = 10'h001;
    wr_ba = 2'd0; wr_bg = 2'd1; wr_row = 17'h00020; wr_col = 10'h002;
    rd_valid = 1'b1; wr_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      rdy = 2'b00;
      for (int c = 0; c < 20 && rdy == 2'b00; c++) begin
        tick();
        rdy = {rd_ready, wr_ready};
      end
      check_eq($sformatf("t4_rr%0d", k), rdy, (k % 2 == 0) ? 2'b10 : 2'b01);
    end
    rd_valid = 1'b0; wr_valid = 1'b0;
    tick();

    // Reset inside WAIT_RCD aborts; the held request restarts with ACT.
    rd_ba = 2'd0; rd_bg = 2'd2; rd_row = 17'h00777; rd_col = 10'h005; rd_valid = 1'b1;
    tick();
    check_eq("t6_act", bus1(), bus(1'b0, 1'b0, 17'h00777, 2'd0, 2'd2));
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_bus", bus1(), DESEL);
    check_eq("t6_rst_flags", {rd_ready, busy}, 2'b00);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check_eq("t6_react", bus1(), bus(1'b0, 1'b0, 17'h00777, 2'd0, 2'd2));
    tick(); tick(); tick(); tick();
    check_eq("t6_rd", bus1(), bus(1'b0, 1'b1, 17'h14005, 2'd0, 2'd2));
    rd_valid = 1'b0;
    tick();

    // Refresh on the T_REFI=50 instance, cycle 0 = first cycle after reset release.
    rst2_n = 1'b1;
    rd2_valid = 1'b1;
    quiet_bad = 0;
    for (int cyc = 1; cyc <= 95; cyc++) begin
      tick();
      if (cyc == 1)  check_eq("t5_act", bus2(), bus(1'b0, 1'b0, 17'h00123, 2'd1, 2'd1));
      if (cyc == 5)  check_eq("t5_rd_ready", rd2_ready, 1'b1);
      if (cyc == 49) check_eq("t5_pend_early", pend2, 1'b0);
      if (cyc == 50) check_eq("t5_pend", pend2, 1'b1);
      if (cyc == 51) check_eq("t5_prea", bus2(), bus(1'b0, 1'b1, 17'h08400, 2'd0, 2'd0));
      if (cyc == 55) begin
        check_eq("t5_ref", bus2(), bus(1'b0, 1'b1, 17'h04000, 2'd0, 2'd0));
        check_eq("t5_pend_at_ref", pend2, 1'b1);
      end
      if (cyc == 56) check_eq("t5_pend_clr", pend2, 1'b0);
      if (cyc >= 56 && cyc <= 87 && bus2() !== DESEL) quiet_bad++;
      if (cyc == 88) begin
        check_eq("t5_rfc_quiet", quiet_bad, 0);
        rd2_valid = 1'b1;
      end
      if (cyc == 89) check_eq("t5_closed", bus2(), bus(1'b0, 1'b0, 17'h00123, 2'd1, 2'd1));
      if (cyc == 93) check_eq("t5_rd2", bus2(), bus(1'b0, 1'b1, 17'h14010, 2'd1, 2'd1));
      if (rd2_ready) rd2_valid = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
